// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x branch resolution slice.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CMP = 2'd1,
        REDIRECT = 2'd2
    } bch_resolve_state_e;

    localparam logic [31:0] PC_INC_RVC  = 32'd2;
    localparam logic [31:0] PC_INC_RV32 = 32'd4;

endpackage

// File: rtl/cv32e40x_bch_mispredict_cnt.sv
// Saturating mispredict counter; only instantiated when CV32E40X_BCH_STATS_EN is defined.
module cv32e40x_bch_mispredict_cnt
    import cv32e40x_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Stick at all-ones so a long run never wraps back to a small count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cv32e40x_bch_resolve.sv
// Conditional branch resolution: compares the static prediction with the EX outcome and redirects IF on mispredict.
// Define CV32E40X_BCH_STATS_EN to build in the saturating mispredict counter.
module cv32e40x_bch_resolve
    import cv32e40x_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic [31:0]          id_pc_i,
    input  logic                 id_compressed_i,
    input  logic [31:0]          id_bch_target_i,
    input  logic                 id_bch_prediction_i,
    input  logic                 ex_cmp_valid_i,
    input  logic                 ex_cmp_taken_i,
    input  logic                 kill_i,
    output logic                 flush_o,
    output logic                 redirect_valid_o,
    input  logic                 redirect_ready_i,
    output logic [31:0]          redirect_pc_o,
    output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

    bch_resolve_state_e r_state;
    logic [31:0]        r_pc;
    logic               r_compressed;
    logic [31:0]        r_target;
    logic               r_pred;
    logic [31:0]        r_redirect_pc;
    logic               r_flush;

    logic               w_accept;
    logic               w_mispredict;
    logic [31:0]        w_seq_pc;

    // Kill wins over every other event, including a same-cycle handshake from ID
    assign w_accept     = id_valid_i & (r_state == IDLE) & ~kill_i;
    assign w_mispredict = (r_state == WAIT_CMP) & ex_cmp_valid_i & ~kill_i
                          & (ex_cmp_taken_i != r_pred);
    assign w_seq_pc     = r_pc + (r_compressed ? PC_INC_RVC : PC_INC_RV32);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_compressed  <= 1'b0;
            r_target      <= '0;
            r_pred        <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= w_mispredict;
            if (w_accept) begin
                r_pc         <= id_pc_i;
                r_compressed <= id_compressed_i;
                r_target     <= id_bch_target_i;
                r_pred       <= id_bch_prediction_i;
            end
            if (w_mispredict) begin
                r_redirect_pc <= ex_cmp_taken_i ? r_target : w_seq_pc;
            end
            if (kill_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE:     if (w_accept) r_state <= WAIT_CMP;
                    WAIT_CMP: if (ex_cmp_valid_i) r_state <= w_mispredict ? REDIRECT : IDLE;
                    REDIRECT: if (redirect_ready_i) r_state <= IDLE;
                    default:  r_state <= IDLE;
                endcase
            end
        end
    end

    assign id_ready_o       = (r_state == IDLE);
    assign redirect_valid_o = (r_state == REDIRECT);
    assign flush_o          = r_flush;
    assign redirect_pc_o    = r_redirect_pc;

`ifdef CV32E40X_BCH_STATS_EN
    cv32e40x_bch_mispredict_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_mispredict),
        .o_cnt (mispredict_cnt_o)
    );
`else
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40x_bch_resolve.sv
// Testbench for cv32e40x_bch_resolve (CNT_WIDTH=2); counter expectations follow CV32E40X_BCH_STATS_EN.
module tb_cv32e40x_bch_resolve;

    localparam int CntWidth = 2;
    localparam int CntMax   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid_i;
    logic                id_ready_o;
    logic [31:0]         id_pc_i;
    logic                id_compressed_i;
    logic [31:0]         id_bch_target_i;
    logic                id_bch_prediction_i;
    logic                ex_cmp_valid_i;
    logic                ex_cmp_taken_i;
    logic                kill_i;
    logic                flush_o;
    logic                redirect_valid_o;
    logic                redirect_ready_i;
    logic [31:0]         redirect_pc_o;
    logic [CntWidth-1:0] mispredict_cnt_o;

    int          testCount = 0;
    int          failCount = 0;
    int          expCnt    = 0;
    logic [31:0] expQueue[$];

    cv32e40x_bch_resolve #(
        .CNT_WIDTH (CntWidth)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_valid_i          (id_valid_i),
        .id_ready_o          (id_ready_o),
        .id_pc_i             (id_pc_i),
        .id_compressed_i     (id_compressed_i),
        .id_bch_target_i     (id_bch_target_i),
        .id_bch_prediction_i (id_bch_prediction_i),
        .ex_cmp_valid_i      (ex_cmp_valid_i),
        .ex_cmp_taken_i      (ex_cmp_taken_i),
        .kill_i              (kill_i),
        .flush_o             (flush_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_ready_i    (redirect_ready_i),
        .redirect_pc_o       (redirect_pc_o),
        .mispredict_cnt_o    (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic noteMispredict();
`ifdef CV32E40X_BCH_STATS_EN
        if (expCnt < CntMax) expCnt++;
`endif
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst    = 1'b0;
        expCnt = 0;
    endtask

    task automatic offerBranch(input logic [31:0] pc, input logic comp, input logic [31:0] tgt, input logic pred);
        id_valid_i          = 1'b1;
        id_pc_i             = pc;
        id_compressed_i     = comp;
        id_bch_target_i     = tgt;
        id_bch_prediction_i = pred;
        stepCycle();
        id_valid_i = 1'b0;
        checkOutput("ready_in_wait", 32'(id_ready_o), 32'd0);
    endtask

    // One complete branch; readyDelay is how many cycles IF stalls the redirect
    task automatic applyStimulus(input logic [31:0] pc, input logic comp, input logic [31:0] tgt,
                                 input logic pred, input logic taken, input int readyDelay);
        logic [31:0] expPc;
        logic        mis;
        mis   = (pred != taken);
        expPc = taken ? tgt : (pc + (comp ? 32'd2 : 32'd4));
        offerBranch(pc, comp, tgt, pred);
        if (mis) expQueue.push_back(expPc);
        ex_cmp_valid_i = 1'b1;
        ex_cmp_taken_i = taken;
        stepCycle();
        ex_cmp_valid_i = 1'b0;
        if (!mis) begin
            checkOutput("hit_flush", 32'(flush_o), 32'd0);
            checkOutput("hit_redirect", 32'(redirect_valid_o), 32'd0);
            checkOutput("hit_idle", 32'(id_ready_o), 32'd1);
            return;
        end
        noteMispredict();
        checkOutput("mis_flush", 32'(flush_o), 32'd1);
        checkOutput("mis_valid", 32'(redirect_valid_o), 32'd1);
        checkOutput("mis_pc", redirect_pc_o, expPc);
        checkOutput("mis_ready", 32'(id_ready_o), 32'd0);
        for (int i = 0; i < readyDelay; i++) begin
            stepCycle();
            checkOutput("stall_flush", 32'(flush_o), 32'd0);
            checkOutput("stall_valid", 32'(redirect_valid_o), 32'd1);
            checkOutput("stall_pc", redirect_pc_o, expPc);
        end
        redirect_ready_i = 1'b1;
        stepCycle();
        redirect_ready_i = 1'b0;
        checkOutput("post_valid", 32'(redirect_valid_o), 32'd0);
        checkOutput("post_idle", 32'(id_ready_o), 32'd1);
    endtask

    // Scoreboard: every accepted redirect must match the oldest expected address
    always @(negedge clk) begin
        if (!rst && redirect_valid_o && redirect_ready_i) begin
            if (expQueue.size() == 0) begin
                checkOutput("sb_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("sb_redirect_pc", redirect_pc_o, expQueue.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                 = 1'b1;
        id_valid_i          = 1'b0;
        id_pc_i             = '0;
        id_compressed_i     = 1'b0;
        id_bch_target_i     = '0;
        id_bch_prediction_i = 1'b0;
        ex_cmp_valid_i      = 1'b0;
        ex_cmp_taken_i      = 1'b0;
        kill_i              = 1'b0;
        redirect_ready_i    = 1'b0;
        applyReset();

        checkOutput("rst_ready", 32'(id_ready_o), 32'd1);
        checkOutput("rst_flush", 32'(flush_o), 32'd0);
        checkOutput("rst_valid", 32'(redirect_valid_o), 32'd0);
        checkOutput("rst_pc", redirect_pc_o, 32'd0);
        checkOutput("rst_cnt", 32'(mispredict_cnt_o), 32'd0);

        ex_cmp_valid_i = 1'b1;
        ex_cmp_taken_i = 1'b1;
        stepCycle();
        ex_cmp_valid_i = 1'b0;
        checkOutput("idle_cmp_flush", 32'(flush_o), 32'd0);
        checkOutput("idle_cmp_valid", 32'(redirect_valid_o), 32'd0);
        checkOutput("idle_cmp_ready", 32'(id_ready_o), 32'd1);

        applyStimulus(32'h0000_0100, 1'b0, 32'h0000_00F0, 1'b1, 1'b1, 0);
        applyStimulus(32'h0000_0100, 1'b0, 32'h0000_00F0, 1'b1, 1'b0, 3);
        applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0240, 1'b0, 1'b1, 0);
        applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0240, 1'b0, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFC, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1);
        applyStimulus(32'h0000_0300, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 0);
        checkOutput("cnt_mid", 32'(mispredict_cnt_o), 32'(expCnt));

        offerBranch(32'h0000_0500, 1'b0, 32'h0000_0600, 1'b1);
        ex_cmp_valid_i = 1'b1;
        ex_cmp_taken_i = 1'b0;
        kill_i         = 1'b1;
        stepCycle();
        ex_cmp_valid_i = 1'b0;
        kill_i         = 1'b0;
        checkOutput("kill_flush", 32'(flush_o), 32'd0);
        checkOutput("kill_valid", 32'(redirect_valid_o), 32'd0);
        checkOutput("kill_idle", 32'(id_ready_o), 32'd1);
        checkOutput("kill_cnt", 32'(mispredict_cnt_o), 32'(expCnt));

        offerBranch(32'h0000_0700, 1'b0, 32'h0000_0800, 1'b0);
        ex_cmp_valid_i = 1'b1;
        ex_cmp_taken_i = 1'b1;
        stepCycle();
        ex_cmp_valid_i = 1'b0;
        noteMispredict();
        checkOutput("pre_rst_valid", 32'(redirect_valid_o), 32'd1);
        rst = 1'b1;
        stepCycle();
        rst    = 1'b0;
        expCnt = 0;
        checkOutput("rst_mid_valid", 32'(redirect_valid_o), 32'd0);
        checkOutput("rst_mid_flush", 32'(flush_o), 32'd0);
        checkOutput("rst_mid_ready", 32'(id_ready_o), 32'd1);
        checkOutput("rst_mid_cnt", 32'(mispredict_cnt_o), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h0000_1000 + 32'(i * 8), 1'(i % 2), 32'h0000_2000, 1'b0, 1'b1, i % 2);
            checkOutput("cnt_step", 32'(mispredict_cnt_o), 32'(expCnt));
        end
`ifdef CV32E40X_BCH_STATS_EN
        checkOutput("cnt_saturated", 32'(mispredict_cnt_o), 32'd3);
`else
        checkOutput("cnt_tied_zero", 32'(mispredict_cnt_o), 32'd0);
`endif
        stepCycle();
        checkOutput("sb_drained", 32'(expQueue.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
